// File: rtl/cache_fill_fsm.sv
// Cache block fill engine: on a miss, reads BLOCK_WORDS words from main memory,
// streams each returned word into the data array, then issues one tag write.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic [15:0] mem_data,
    input  logic        mem_data_valid,
    output logic        fsm_busy,
    output logic        mem_ren,
    output logic [15:0] mem_addr,
    output logic        write_data_array,
    output logic        write_tag_array,
    output logic [15:0] fill_addr,
    output logic [15:0] fill_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_WORDS - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [15:0]      r_base;
    logic [CNT_W-1:0] r_issue_cnt;
    logic [CNT_W-1:0] r_recv_cnt;

    logic             w_issue_active;
    logic             w_recv;
    logic [CNT_W-1:0] w_issue_idx;
    logic [15:0]      w_issue_addr;
    logic [15:0]      w_recv_addr;

    assign w_issue_active = (r_state == FILL) && (r_issue_cnt < FULL_CNT);
    assign w_recv         = (r_state == FILL) && mem_data_valid;
    // After the last request the read address parks on the final word.
    assign w_issue_idx    = w_issue_active ? r_issue_cnt : LAST_CNT;
    assign w_issue_addr   = r_base + (16'(w_issue_idx) << 1);
    assign w_recv_addr    = r_base + (16'(r_recv_cnt) << 1);

    // NOTE: sequential state uses non-blocking assignments and an async reset
    // in the sensitivity list, so every flop clears the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (miss_detected) w_next_state = FILL;
            FILL: if (mem_data_valid && (r_recv_cnt == LAST_CNT)) w_next_state = TAG;
            TAG:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base      <= 16'h0000;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else if (r_state == IDLE) begin
            if (miss_detected) begin
                r_base      <= {miss_address[15:4], 4'b0000};
                r_issue_cnt <= '0;
                r_recv_cnt  <= '0;
            end
        end else if (r_state == FILL) begin
            // Issue and receive advance independently; both may step in one cycle.
            if (w_issue_active) r_issue_cnt <= r_issue_cnt + 1'b1;
            if (w_recv)         r_recv_cnt  <= r_recv_cnt + 1'b1;
        end
    end

    always_comb begin
        fsm_busy         = 1'b0;
        mem_ren          = 1'b0;
        mem_addr         = 16'h0000;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_addr        = 16'h0000;
        case (r_state)
            FILL: begin
                fsm_busy         = 1'b1;
                mem_ren          = w_issue_active;
                mem_addr         = w_issue_addr;
                write_data_array = w_recv;
                fill_addr        = w_recv_addr;
            end
            TAG: begin
                fsm_busy         = 1'b1;
                mem_addr         = w_issue_addr;
                write_tag_array  = 1'b1;
                fill_addr        = r_base;
            end
            default: ;
        endcase
    end

    assign fill_data = mem_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a latency/stall memory model feeds the
// DUT while a scoreboard predicts request, write and tag activity per cycle.
module tb_cache_fill_fsm;

    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0000;
    logic [15:0] mem_data = 16'h0000;
    logic        mem_data_valid = 1'b0;
    logic        fsm_busy;
    logic        mem_ren;
    logic [15:0] mem_addr;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;

    int n_vec = 0;
    int n_err = 0;

    cache_fill_fsm #(.BLOCK_WORDS(BW), .CNT_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .mem_data         (mem_data),
        .mem_data_valid   (mem_data_valid),
        .fsm_busy         (fsm_busy),
        .mem_ren          (mem_ren),
        .mem_addr         (mem_addr),
        .write_data_array (write_data_array),
        .write_tag_array  (write_tag_array),
        .fill_addr        (fill_addr),
        .fill_data        (fill_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          lat;
        int          gate;
        bit          hold;
        int          abort_after;
        logic [15:0] exp_base;
        int          exp_busy;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        int          cyc;
    } req_t;

    req_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic bit gate_ok(input int mode, input int cyc);
        if (mode == 1) return (cyc % 2) == 0;
        if (mode == 2) return ($urandom % 4) != 0;
        return 1'b1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, fsm_busy, 0);
        check({tag, "_ren"}, mem_ren, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_wr_data"}, write_data_array, 0);
        check({tag, "_wr_tag"}, write_tag_array, 0);
        check({tag, "_fill_addr"}, fill_addr, 0);
        check({tag, "_fill_data"}, fill_data, 0);
    endtask

    // Entered and left at a falling edge.
    task automatic run_fill(input vec_t v);
        int cyc;
        int nwr;
        bit done;
        bit aborted;
        bit exp_wr;
        bit exp_tag;
        q.delete();
        miss_address  = v.addr;
        miss_detected = 1'b1;
        @(posedge clk);
        #1;
        miss_detected = v.hold;
        cyc = 1; nwr = 0; done = 0; aborted = 0;
        while (!done && !aborted) begin
            miss_address = 16'($urandom);
            if (q.size() > 0 && (q[0].cyc + v.lat <= cyc) && gate_ok(v.gate, cyc)) begin
                mem_data_valid = 1'b1;
                mem_data       = word_of(q[0].addr);
                void'(q.pop_front());
            end else begin
                mem_data_valid = 1'b0;
                mem_data       = 16'($urandom);
            end
            @(negedge clk);
            exp_tag = (nwr == BW);
            exp_wr  = mem_data_valid && (nwr < BW);
            check("busy", fsm_busy, 1);
            check("mem_ren", mem_ren, 32'(cyc <= BW));
            if (cyc <= BW) check("mem_addr", mem_addr, v.exp_base + 16'(2 * (cyc - 1)));
            if (mem_ren) q.push_back('{mem_addr, cyc});
            check("wr_data", write_data_array, 32'(exp_wr));
            check("wr_tag", write_tag_array, 32'(exp_tag));
            if (exp_wr) begin
                check("fill_addr", fill_addr, v.exp_base + 16'(2 * nwr));
                check("fill_data", fill_data, word_of(v.exp_base + 16'(2 * nwr)));
                nwr++;
            end
            if (exp_tag) begin
                check("tag_addr", fill_addr, v.exp_base);
                done = 1;
            end else if (v.abort_after > 0 && nwr == v.abort_after) begin
                #1;
                rst_n          = 1'b0;
                mem_data_valid = 1'b0;
                mem_data       = 16'h0000;
                #1;
                check_all_zero("rst_mid");
                @(negedge clk);
                check_all_zero("rst_hold");
                rst_n = 1'b1;
                q.delete();
                aborted = 1;
            end else if (cyc >= 300) begin
                check("fill_timeout", 0, 1);
                aborted = 1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (done) begin
            if (v.exp_busy >= 0) check("busy_cycles", cyc, v.exp_busy);
            @(posedge clk);
            #1;
            mem_data_valid = 1'b0;
            @(negedge clk);
            check("idle_busy", fsm_busy, 0);
            check("idle_ren", mem_ren, 0);
            check("idle_wr_tag", write_tag_array, 0);
            check("idle_wr_data", write_data_array, 0);
        end
    endtask

    vec_t vecs[7];
    vec_t rv;

    initial begin
        vecs[0] = '{16'h1234, 4, 0, 1'b0, 0, 16'h1230, 13};
        vecs[1] = '{16'hFFF6, 4, 0, 1'b0, 0, 16'hFFF0, 13};
        vecs[2] = '{16'h5678, 1, 1, 1'b0, 0, 16'h5670, 17};
        vecs[3] = '{16'h2000, 4, 0, 1'b0, 3, 16'h2000, -1};
        vecs[4] = '{16'h0040, 4, 0, 1'b0, 0, 16'h0040, 13};
        vecs[5] = '{16'h3ABC, 2, 0, 1'b1, 0, 16'h3AB0, 11};
        vecs[6] = '{16'h7FFF, 3, 0, 1'b0, 0, 16'h7FF0, 12};

        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Valid data with no fill in progress must be ignored.
        mem_data_valid = 1'b1;
        mem_data       = 16'hBEEF;
        @(negedge clk);
        check("spur_wr", write_data_array, 0);
        check("spur_busy", fsm_busy, 0);
        check("spur_fill_data", fill_data, 16'hBEEF);
        @(negedge clk);
        check("spur_wr2", write_data_array, 0);
        check("spur_ren", mem_ren, 0);
        mem_data_valid = 1'b0;
        mem_data       = 16'h0000;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_fill(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            rv.addr        = 16'($urandom);
            rv.lat         = 1 + int'($urandom % 6);
            rv.gate        = 2;
            rv.hold        = 1'b0;
            rv.abort_after = 0;
            rv.exp_base    = rv.addr & 16'hFFF0;
            rv.exp_busy    = -1;
            run_fill(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Memory-side responder to the cache's miss indication. When the cache raises `miss_detected`, this block fetches the 16-byte (8-word) block at `miss_address` from the multicycle main memory. It streams each returned word into the cache data array with an explicit word address, then writes the tag/metadata once the last word lands. It sits between the cache and main memory, with one instance each for the I-cache and the D-cache.

## Interface
Parameters:
- `BLOCK_WORDS`, default 8: words per cache block; address stride is 2 bytes per word.
- `CNT_W`, default 4: width of the issue and receive counters; must hold `BLOCK_WORDS`.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `miss_detected`  in  1  cache miss indication (level).
- `miss_address`  in  16  block start address from cache; bits [3:0] are ignored.
- `mem_data`  in  16  word returned by memory.
- `mem_data_valid`  in  1  `mem_data` is valid this cycle.
- `fsm_busy`  out  1  fill in progress; the pipeline stalls on this.
- `mem_ren`  out  1  memory read request this cycle.
- `mem_addr`  out  16  memory read address.
- `write_data_array`  out  1  write `fill_data` into the data array at `fill_addr`.
- `write_tag_array`  out  1  write tag, valid and LRU for the set of `fill_addr`.
- `fill_addr`  out  16  word address for the cache write.
- `fill_data`  out  16  word to write; equals `mem_data`.

## Operation
- State register: IDLE, FILL, TAG. Encoding is free; the reset state is IDLE.
- Internal registers:
  - `base[15:0]`
  - `issue_cnt[CNT_W-1:0]`
  - `recv_cnt[CNT_W-1:0]`
- **IDLE**
  - If `miss_detected`=1 at a clock edge:
    - latch `base` = {`miss_address`[15:4], 4'b0};
    - clear both counters;
    - go to FILL.
  - Otherwise stay in IDLE.
  - `mem_data_valid` is ignored in IDLE.
- **FILL**
  - Issue side:
    - While `issue_cnt` < `BLOCK_WORDS`: `mem_ren`=1 and `mem_addr` = `base` + 2×`issue_cnt`, then `issue_cnt` increments each cycle.
    - Once `issue_cnt` = `BLOCK_WORDS`: `mem_ren`=0 and `mem_addr` holds its last value.
  - Receive side, in any FILL cycle with `mem_data_valid`=1:
    - `write_data_array`=1;
    - `fill_addr` = `base` + 2×`recv_cnt`;
    - `recv_cnt` increments.
  - Gaps in `mem_data_valid` are legal; the receive side simply waits.
  - When `mem_data_valid`=1 and `recv_cnt` = `BLOCK_WORDS`−1, go to TAG.
- **TAG**
  - Hold for exactly one cycle with `write_tag_array`=1, `fill_addr` = `base`, `write_data_array`=0.
  - Then go to IDLE.
- `fsm_busy` = 1 in FILL and TAG, and 0 in IDLE.
- `miss_detected` is not sampled while busy. If it is still high at the first IDLE cycle after TAG, a new fill starts (the cache only deasserts it after the tag write hits).
- Address arithmetic is 16-bit. `base` is 16-aligned, so `base`+14 never carries out of bits [3:0]; no wrap handling is needed.
- `fill_data` = `mem_data` combinationally. `write_data_array`, `write_tag_array` and `fill_addr` are combinational from state, counters and `mem_data_valid`.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state goes to IDLE;
  - `base`, `issue_cnt` and `recv_cnt` clear to 0;
  - all outputs read 0 while in reset and in IDLE: `fsm_busy`, `mem_ren`, `write_data_array`, `write_tag_array` are 0; `mem_addr`, `fill_addr`, `fill_data` are 0x0000 (`fill_data` reads 0 only when `mem_data` is 0 — see the IDLE gating note below).
- Reset mid-FILL or mid-TAG: the fill is abandoned with no tag write. Memory is reset on the same `rst_n`, so no stale returns arrive afterward.
- Miss sampled at edge N:
  - `fsm_busy`=1 and the first `mem_ren` appear in cycle N+1;
  - requests occupy cycles N+1 through N+8.
- With fixed memory latency L (data valid L cycles after a request):
  - words are written in cycles N+1+L through N+8+L;
  - TAG is cycle N+9+L;
  - `fsm_busy` falls after edge N+10+L.
- If a word returns in the same cycle as a request is issued, both are handled in that cycle.
- The minimum fill with L=4 is 13 busy cycles.
- In IDLE, `fill_data` is still driven by `mem_data`, but `write_data_array`=0 gates it.

## Test plan
- **Single miss:** `miss_address`=0x1234, L=4.
  - `mem_addr` steps 0x1230, 0x1232 … 0x123E over 8 consecutive `mem_ren` cycles.
  - 8 `write_data_array` pulses with `fill_addr` 0x1230 … 0x123E and `fill_data` equal to the memory words.
  - One `write_tag_array` pulse with `fill_addr`=0x1230.
  - `fsm_busy` is high for exactly 13 cycles.
- **Top of memory:** `miss_address`=0xFFF6.
  - `base`=0xFFF0, the last request is 0xFFFE, and no address exceeds 0xFFFE.
- **Stalling memory:** `mem_data_valid` is toggled 1,0,1,0…
  - Exactly 8 data writes occur, in address order.
  - TAG comes only after the 8th valid word; busy extends accordingly.
- **Reset mid-fill:** drop `rst_n` after the 3rd data write.
  - All outputs go to 0 immediately, with no `write_tag_array`.
  - A later miss at 0x0040 fills cleanly from 0x0040.
- **Spurious and held inputs:**
  - `mem_data_valid` pulsed in IDLE produces no write.
  - `miss_detected` held high through TAG restarts a fill in the first IDLE cycle.
  - `miss_address` changing mid-fill does not alter `base`.
